// File: rtl/audio_frame_feeder.sv
// Producer-side driver for audio_min_max: buffers an N-sample frame from a valid/ready
// stream, sequences the engine's reset/start, and reports its min/max (or a timeout) upstream.
module audio_frame_feeder #(
   parameter int unsigned N       = 100,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [31:0]         in_data,
   output logic                in_ready,
   output logic                mm_reset,
   output logic                mm_start,
   output logic [N*32-1:0]     mm_audio,
   input  logic                mm_done,
   input  logic [31:0]         mm_max,
   input  logic [31:0]         mm_min,
   output logic                res_valid,
   output logic [31:0]         res_max,
   output logic [31:0]         res_min,
   output logic                res_timeout,
   output logic [15:0]         frame_count
);

   localparam int unsigned SW    = 32;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      FILL   = 3'd0,
      CLR    = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      REPORT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N*SW-1:0]   buf_q, buf_d;
   logic              in_ready_q, in_ready_d;
   logic              mm_reset_q, mm_reset_d;
   logic              mm_start_q, mm_start_d;
   logic              res_valid_q, res_valid_d;
   logic [31:0]       res_max_q, res_max_d;
   logic [31:0]       res_min_q, res_min_d;
   logic              res_timeout_q, res_timeout_d;
   logic [15:0]       frame_count_q, frame_count_d;

   // Next-state and registered-output decode; handshake outputs follow the next state
   // so they line up with the state they describe.
   always_comb begin
      state_d       = state_q;
      wr_idx_d      = wr_idx_q;
      cnt_d         = cnt_q;
      buf_d         = buf_q;
      res_valid_d   = 1'b0;
      res_max_d     = res_max_q;
      res_min_d     = res_min_q;
      res_timeout_d = res_timeout_q;
      frame_count_d = frame_count_q;

      case (state_q)
         FILL: begin
            if (in_valid && in_ready_q) begin
               buf_d[SW*int'(wr_idx_q) +: SW] = in_data;
               if (wr_idx_q == IDX_W'(N - 1)) begin
                  wr_idx_d = '0;
                  state_d  = CLR;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         CLR:   state_d = START;
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done seen on the final timeout cycle still wins.
            if (mm_done) begin
               res_max_d     = mm_max;
               res_min_d     = mm_min;
               res_timeout_d = 1'b0;
               res_valid_d   = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = REPORT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = REPORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPORT:  state_d = FILL;
         default: state_d = FILL;
      endcase

      in_ready_d = (state_d == FILL);
      mm_reset_d = (state_d == CLR);
      mm_start_d = (state_d == START);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         wr_idx_q      <= '0;
         cnt_q         <= '0;
         in_ready_q    <= 1'b0;
         mm_reset_q    <= 1'b1;
         mm_start_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         res_max_q     <= '0;
         res_min_q     <= '0;
         res_timeout_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wr_idx_q      <= wr_idx_d;
         cnt_q         <= cnt_d;
         in_ready_q    <= in_ready_d;
         mm_reset_q    <= mm_reset_d;
         mm_start_q    <= mm_start_d;
         res_valid_q   <= res_valid_d;
         res_max_q     <= res_max_d;
         res_min_q     <= res_min_d;
         res_timeout_q <= res_timeout_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Frame buffer is not reset: every word is rewritten before the engine is started.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign in_ready    = in_ready_q;
   assign mm_reset    = mm_reset_q;
   assign mm_start    = mm_start_q;
   assign mm_audio    = buf_q;
   assign res_valid   = res_valid_q;
   assign res_max     = res_max_q;
   assign res_min     = res_min_q;
   assign res_timeout = res_timeout_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Bench for audio_frame_feeder with a behavioural min/max engine stand-in.
module tb_audio_frame_feeder;

   localparam int N       = 100;
   localparam int TIMEOUT = 1024;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [31:0]     in_data;
   logic            in_ready;
   logic            mm_reset;
   logic            mm_start;
   logic [N*32-1:0] mm_audio;
   logic            mm_done;
   logic [31:0]     mm_max;
   logic [31:0]     mm_min;
   logic            res_valid;
   logic [31:0]     res_max;
   logic [31:0]     res_min;
   logic            res_timeout;
   logic [15:0]     frame_count;

   audio_frame_feeder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mm_reset(mm_reset), .mm_start(mm_start),
      .mm_audio(mm_audio), .mm_done(mm_done), .mm_max(mm_max), .mm_min(mm_min),
      .res_valid(res_valid), .res_max(res_max), .res_min(res_min),
      .res_timeout(res_timeout), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cnt = 0, start_cyc = 0, rst_cyc = 0, rv_cnt = 0, rv_cyc = 0;
   int last_acc = 0, fill_drops = 0;
   bit hang = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine stand-in: sticky done a few cycles after start, cleared by mm_reset.
   logic        eng_done = 1'b0, eng_busy = 1'b0;
   logic [2:0]  eng_cnt = '0;
   logic [31:0] eng_max = '0, eng_min = '0;

   function automatic logic [63:0] minmax(input logic [N*32-1:0] a);
      logic signed [31:0] mn, mx, v;
      mn = a[31:0];
      mx = mn;
      for (int i = 1; i < N; i++) begin
         v = a[i*32 +: 32];
         if (v < mn) mn = v;
         if (v > mx) mx = v;
      end
      return {mx, mn};
   endfunction

   always @(posedge clk) begin
      if (mm_reset) begin
         eng_done <= 1'b0;
         eng_busy <= 1'b0;
      end else if (mm_start && !hang) begin
         eng_busy <= 1'b1;
         eng_cnt  <= 3'd4;
      end else if (eng_busy) begin
         if (eng_cnt == 3'd0) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b1;
            {eng_max, eng_min} <= minmax(mm_audio);
         end else begin
            eng_cnt <= eng_cnt - 3'd1;
         end
      end
   end

   assign mm_done = eng_done;
   assign mm_max  = eng_max;
   assign mm_min  = eng_min;

   always @(negedge clk) begin
      if (mm_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (mm_reset) rst_cyc = cyc;
      if (res_valid) begin
         rv_cnt++;
         rv_cyc = cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] samp(input int pat, input int k);
      case (pat)
         0:       return 32'(k);
         1:       return 32'd42;
         2:       return (k % 2 == 0) ? 32'hFFFF_FF9C : 32'd100;
         3:       return 32'((k - 50) * 1000);
         4:       return (k == 0) ? 32'h7FFF_FFFF : (k == N - 1) ? 32'h8000_0000 : 32'(k);
         default: return 32'd5;
      endcase
   endfunction

   task automatic send(input int pat, input bit gap, input int first, input int last);
      int  tries;
      bit  acc;
      for (int k = first; k <= last; k++) begin
         if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
            if (!in_ready) fill_drops++;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = samp(pat, k);
         tries = 0;
         acc   = 1'b0;
         while (!acc && tries < 50) begin
            @(negedge clk);
            if (in_ready) begin
               acc = 1'b1;
               last_acc = cyc;
            end else begin
               fill_drops++;
               tries++;
            end
            @(posedge clk); #1;
         end
         if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output bit ok);
      int base;
      base = rv_cnt;
      ok   = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk); #1;
         if (rv_cnt != base) ok = 1'b1;
      end
   endtask

   typedef struct {
      int          pat;
      bit          gap;
      logic [31:0] exp_min;
      logic [31:0] exp_max;
   } vec_t;

   vec_t vecs[5];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ok;
      int s0, r0, bp_ready, bp_wr;

      vecs[0] = '{pat: 0, gap: 1'b0, exp_min: 32'd0,          exp_max: 32'd99};
      vecs[1] = '{pat: 1, gap: 1'b1, exp_min: 32'd42,         exp_max: 32'd42};
      vecs[2] = '{pat: 2, gap: 1'b0, exp_min: 32'hFFFF_FF9C,  exp_max: 32'd100};
      vecs[3] = '{pat: 3, gap: 1'b0, exp_min: 32'hFFFF_3CB0,  exp_max: 32'd49000};
      vecs[4] = '{pat: 4, gap: 1'b1, exp_min: 32'h8000_0000,  exp_max: 32'h7FFF_FFFF};

      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mm_reset", 32'(mm_reset), 32'd1);
      chk("rst_mm_start", 32'(mm_start), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_max", res_max, 32'd0);
      chk("rst_res_min", res_min, 32'd0);
      chk("rst_res_timeout", 32'(res_timeout), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_mm_reset", 32'(mm_reset), 32'd0);

      for (int i = 0; i < 5; i++) begin
         s0 = start_cnt; r0 = rv_cnt; fill_drops = 0;
         send(vecs[i].pat, vecs[i].gap, 0, N - 1);
         wait_result(ok);
         chk($sformatf("v%0d_result_seen", i), 32'(ok), 32'd1);
         chk($sformatf("v%0d_res_min", i), res_min, vecs[i].exp_min);
         chk($sformatf("v%0d_res_max", i), res_max, vecs[i].exp_max);
         chk($sformatf("v%0d_res_timeout", i), 32'(res_timeout), 32'd0);
         chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(i + 1));
         chk($sformatf("v%0d_start_pulses", i), 32'(start_cnt - s0), 32'd1);
         chk($sformatf("v%0d_start_latency", i), 32'(start_cyc - last_acc), 32'd2);
         chk($sformatf("v%0d_clr_before_start", i), 32'(start_cyc - rst_cyc), 32'd1);
         chk($sformatf("v%0d_fill_ready_drops", i), 32'(fill_drops), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_ready_after", i), 32'(in_ready), 32'd1);
         chk($sformatf("v%0d_valid_one_cycle", i), 32'(res_valid), 32'd0);
         chk($sformatf("v%0d_valid_pulses", i), 32'(rv_cnt - r0), 32'd1);
      end

      // Engine never finishes: timeout report keeps the previous min/max.
      hang = 1'b1;
      send(0, 1'b0, 0, N - 1);
      wait_result(ok);
      chk("to_result_seen", 32'(ok), 32'd1);
      chk("to_latency", 32'(rv_cyc - start_cyc), 32'(TIMEOUT + 1));
      chk("to_res_timeout", 32'(res_timeout), 32'd1);
      chk("to_res_max", res_max, 32'h7FFF_FFFF);
      chk("to_res_min", res_min, 32'h8000_0000);
      chk("to_frame_count", 32'(frame_count), 32'd6);
      @(posedge clk); #1;
      chk("to_ready_after", 32'(in_ready), 32'd1);
      hang = 1'b0;

      // Backpressure: a sample held during CLR..REPORT must not be consumed.
      send(0, 1'b0, 0, N - 1);
      in_valid = 1'b1; in_data = 32'd7;
      bp_ready = 0; bp_wr = 0; ok = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk); #1;
         if (in_ready) bp_ready++;
         if (mm_audio[31:0] != 32'd0) bp_wr++;
         if (res_valid) ok = 1'b1;
      end
      chk("bp_result_seen", 32'(ok), 32'd1);
      chk("bp_ready_while_busy", 32'(bp_ready), 32'd0);
      chk("bp_no_write", 32'(bp_wr), 32'd0);
      chk("bp_res_max", res_max, 32'd99);
      chk("bp_res_timeout", 32'(res_timeout), 32'd0);
      @(posedge clk); #1;
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      chk("bp_not_yet_taken", mm_audio[31:0], 32'd0);
      @(posedge clk); #1;
      chk("bp_taken_as_word0", mm_audio[31:0], 32'd7);
      in_valid = 1'b0;
      send(0, 1'b0, 1, N - 1);
      wait_result(ok);
      chk("bp2_result_seen", 32'(ok), 32'd1);
      chk("bp2_res_min", res_min, 32'd1);
      chk("bp2_res_max", res_max, 32'd99);
      chk("bp2_frame_count", 32'(frame_count), 32'd8);
      @(posedge clk); #1;

      // Reset mid-fill discards the partial frame.
      r0 = rv_cnt;
      send(5, 1'b0, 0, 49);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mf_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mf_rst_mm_reset", 32'(mm_reset), 32'd1);
      chk("mf_rst_frame_count", 32'(frame_count), 32'd0);
      chk("mf_rst_res_max", res_max, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      send(0, 1'b0, 0, N - 1);
      wait_result(ok);
      chk("mf_result_seen", 32'(ok), 32'd1);
      chk("mf_res_min", res_min, 32'd0);
      chk("mf_res_max", res_max, 32'd99);
      chk("mf_frame_count", 32'(frame_count), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("mf_result_pulses", 32'(rv_cnt - r0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/audio_frame_feeder.md
Name: audio_frame_feeder

Overview:
- Producer-side driver for `audio_min_max`.
- Accepts a serial stream of signed 32-bit audio samples on a valid/ready handshake and assembles them into an N-sample frame buffer.
- Drives the min/max engine's `reset`/`start`/`raw_audio` inputs, waits for its done flag, then reports the frame's min/max upstream with a one-cycle result strobe.
- Sits between the audio sample source and `audio_min_max`.

Parameters:
- N, 100, samples per frame; must match the `audio_min_max` instance.
- TIMEOUT, 1024, maximum cycles in WAIT before declaring a timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample on in_data is valid.
- in_data  input  32  signed audio sample.
- in_ready  output  1  feeder accepts a sample this cycle.
- mm_reset  output  1  drives `audio_min_max` reset.
- mm_start  output  1  drives `audio_min_max` start.
- mm_audio  output  N*32  flattened frame; sample k occupies bits [32k+31:32k].
- mm_done  input  1  `audio_min_max` done flag (d).
- mm_max  input  32  signed max from the engine.
- mm_min  input  32  signed min from the engine.
- res_valid  output  1  one-cycle strobe: res_max/res_min/res_timeout are fresh.
- res_max  output  32  latched signed frame max.
- res_min  output  32  latched signed frame min.
- res_timeout  output  1  result corresponds to a timed-out frame.
- frame_count  output  16  frames reported since reset; wraps at 65535 -> 0.

Behaviour:
- Reset (synchronous, while reset=1):
  - state=FILL, wr_idx=0, in_ready=0.
  - mm_reset=1, mm_start=0.
  - res_valid=0, res_max=0, res_min=0, res_timeout=0, frame_count=0, timeout counter=0.
  - Frame buffer contents are not cleared, but all N words are overwritten before any start.
- In the first cycle after reset deasserts, in_ready=1.
- States: FILL, CLR, START, WAIT, REPORT.
- FILL:
  - in_ready=1. A sample is accepted when in_valid&&in_ready: buffer[wr_idx]<=in_data, wr_idx++.
  - in_valid gaps stall filling with no side effects.
  - Accepting the sample with wr_idx==N-1 moves to CLR and sets wr_idx=0.
- CLR: one cycle. in_ready=0, mm_reset=1. Clears any stale engine done flag from the previous frame. Next state: START.
- START: one cycle. mm_reset=0, mm_start=1. Next state: WAIT, with the timeout counter cleared.
- WAIT:
  - mm_start=0, in_ready=0. The timeout counter increments each cycle.
  - If mm_done=1: latch res_max<=mm_max, res_min<=mm_min, res_timeout<=0, then go to REPORT.
  - Else, if the counter reaches TIMEOUT-1: res_timeout<=1, leave res_max/res_min unchanged, go to REPORT.
  - If both occur in the same cycle, mm_done has priority.
- REPORT: one cycle. res_valid=1, frame_count++. Next state: FILL, so in_ready=1 on the following cycle.
- Latency: last sample accepted at cycle t -> mm_reset=1 at t+1 -> mm_start=1 at t+2 -> WAIT from t+3. mm_done first seen high in WAIT at cycle w -> res_valid=1 at w+1 -> in_ready=1 at w+2.
- mm_audio:
  - Driven continuously from the buffer.
  - Stable from CLR through REPORT, because no writes occur while in_ready=0.
- in_valid while in_ready=0: the sample is not consumed. The source must hold it (standard valid/ready).
- res_max/res_min/res_timeout hold their values until the next REPORT.
- Reset mid-FILL: the partial frame is discarded and wr_idx returns to 0. No result is reported for it.
- Reset mid-WAIT: the engine result is discarded, no res_valid is produced, and frame_count returns to 0.
- mm_reset is high only in reset and CLR. mm_start is high only in START.

Test Plan:
1. Ramp: stream 0..99 with in_valid held high against a real `audio_min_max` -> single res_valid pulse, res_min=0, res_max=99, res_timeout=0, frame_count=1.
2. Gapped constant: 100 samples of 42 with in_valid toggling every other cycle -> in_ready=1 throughout FILL, res_min=res_max=42; mm_start pulses exactly once, 2 cycles after the 100th accept.
3. Back-to-back frames: alternating -100/+100 frame, then a $random frame -> first result min=-100/max=100; second result matches a software min/max; mm_reset pulses before each mm_start; frame_count=2.
4. Timeout: the engine model never asserts mm_done -> res_valid exactly TIMEOUT+1 cycles after mm_start, res_timeout=1, res_max/res_min unchanged, feeder returns to FILL.
5. Reset mid-fill: 50 samples, pulse reset, then a full ramp 0..99 -> exactly one result (0/99); no result for the partial frame.
6. Backpressure: hold in_valid=1 with sample 7 during WAIT -> no buffer write, the sample is not accepted; it is accepted as buffer[0] on the cycle in_ready returns to 1.
